// File: rtl/video_timing_gen.sv
// Video timing generator: pixel/line counters, sync/enable strobes and an
// image-window address, all registered and aligned to the same pixel.
module video_timing_gen #(
   parameter int ScreenX            = 1366,
   parameter int ScreenY            = 768,
   parameter int BlankingHorizontal = 50,
   parameter int BlankingVertical   = 12,
   parameter int HSyncOffset        = 8,
   parameter int HSyncWidth         = 16,
   parameter int VSyncOffset        = 2,
   parameter int VSyncWidth         = 4,
   parameter int WinX               = 100,
   parameter int WinY               = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        HSync,
   output logic        VSync,
   output logic        DataEnable,
   output logic [10:0] PosX,
   output logic [10:0] PosY,
   output logic        FrameStart,
   output logic        WinEn,
   output logic [13:0] WinAddr
);

   localparam logic [10:0] HLast  = 11'(ScreenX + BlankingHorizontal - 1);
   localparam logic [10:0] VLast  = 11'(ScreenY + BlankingVertical - 1);
   localparam logic [10:0] ActX   = 11'(ScreenX);
   localparam logic [10:0] ActY   = 11'(ScreenY);
   localparam logic [10:0] HsBeg  = 11'(ScreenX + HSyncOffset);
   localparam logic [10:0] HsEnd  = 11'(ScreenX + HSyncOffset + HSyncWidth);
   localparam logic [10:0] VsBeg  = 11'(ScreenY + VSyncOffset);
   localparam logic [10:0] VsEnd  = 11'(ScreenY + VSyncOffset + VSyncWidth);
   localparam logic [10:0] WinXL  = 11'(WinX);
   localparam logic [10:0] WinYL  = 11'(WinY);
   localparam logic [13:0] WaLast = 14'(WinX * WinY - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [10:0] pos_x_q, pos_x_d;
   logic [10:0] pos_y_q, pos_y_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        de_q, de_d;
   logic        fs_q, fs_d;
   logic        win_en_q, win_en_d;
   logic [13:0] win_addr_q, win_addr_d;
   logic        active_d;
   logic        last_px;

   // Next state and next position; all strobes are derived from the next
   // position so every registered output describes the same pixel.
   always_comb begin
      state_d    = state_q;
      pos_x_d    = '0;
      pos_y_d    = '0;
      fs_d       = 1'b0;
      win_addr_d = '0;
      last_px    = (pos_x_q == HLast) && (pos_y_q == VLast);
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = RUN;
               fs_d    = 1'b1;
            end
         end
         default: begin
            // RUN and DRAIN count identically; only the frame boundary differs
            if (last_px) begin
               state_d = run ? RUN : IDLE;
               fs_d    = run;
            end else begin
               state_d = run ? RUN : DRAIN;
               if (pos_x_q == HLast) begin
                  pos_y_d = pos_y_q + 11'd1;
               end else begin
                  pos_x_d = pos_x_q + 11'd1;
                  pos_y_d = pos_y_q;
               end
            end
         end
      endcase

      active_d = (state_d != IDLE);
      de_d     = active_d && (pos_x_d < ActX) && (pos_y_d < ActY);
      hsync_d  = !(active_d && (pos_x_d >= HsBeg) && (pos_x_d < HsEnd));
      vsync_d  = !(active_d && (pos_y_d >= VsBeg) && (pos_y_d < VsEnd));
      win_en_d = de_d && (pos_x_d < WinXL) && (pos_y_d < WinYL);

      // address advances after each window pixel, restarts every frame
      if (active_d && !fs_d) begin
         if (win_en_q)
            win_addr_d = (win_addr_q == WaLast) ? 14'd0 : win_addr_q + 14'd1;
         else
            win_addr_d = win_addr_q;
      end
   end

   // State and output registers; reset forces the idle picture immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pos_x_q    <= '0;
         pos_y_q    <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         de_q       <= 1'b0;
         fs_q       <= 1'b0;
         win_en_q   <= 1'b0;
         win_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         de_q       <= de_d;
         fs_q       <= fs_d;
         win_en_q   <= win_en_d;
         win_addr_q <= win_addr_d;
      end
   end

   assign HSync      = hsync_q;
   assign VSync      = vsync_q;
   assign DataEnable = de_q;
   assign PosX       = pos_x_q;
   assign PosY       = pos_y_q;
   assign FrameStart = fs_q;
   assign WinEn      = win_en_q;
   assign WinAddr    = win_addr_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with small timing parameters; a frame-index
// reference model predicts every output on every cycle.
module tb_video_timing_gen;

   localparam int SX = 8, BH = 4, SY = 4, BV = 2;
   localparam int HO = 1, HW = 2, VO = 0, VW = 1, WX = 2, WY = 2;
   localparam int HT = SX + BH, VT = SY + BV, FR = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        HSync, VSync, DataEnable, FrameStart, WinEn;
   logic [10:0] PosX, PosY;
   logic [13:0] WinAddr;

   int checks = 0;
   int errors = 0;

   // model: whether a frame is in progress and the pixel index within it
   bit m_active = 1'b0;
   int m_cnt = 0;

   video_timing_gen #(
      .ScreenX(SX), .ScreenY(SY), .BlankingHorizontal(BH), .BlankingVertical(BV),
      .HSyncOffset(HO), .HSyncWidth(HW), .VSyncOffset(VO), .VSyncWidth(VW),
      .WinX(WX), .WinY(WY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .HSync(HSync), .VSync(VSync),
      .DataEnable(DataEnable), .PosX(PosX), .PosY(PosY),
      .FrameStart(FrameStart), .WinEn(WinEn), .WinAddr(WinAddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // compare every output with the model's view of the current pixel
   task automatic check_all();
      int x, y, wcnt;
      bit de, we;
      x  = m_active ? m_cnt % HT : 0;
      y  = m_active ? m_cnt / HT : 0;
      de = m_active && x < SX && y < SY;
      we = de && x < WX && y < WY;
      // window pixels already visited this frame, modulo window size
      wcnt = ((y < WY ? y : WY) * WX + (y < WY ? (x < WX ? x : WX) : 0)) % (WX * WY);
      chk("PosX", 32'(PosX), 32'(x));
      chk("PosY", 32'(PosY), 32'(y));
      chk("DataEnable", 32'(DataEnable), 32'(de));
      chk("HSync", 32'(HSync), 32'(!(m_active && x >= SX + HO && x < SX + HO + HW)));
      chk("VSync", 32'(VSync), 32'(!(m_active && y >= SY + VO && y < SY + VO + VW)));
      chk("FrameStart", 32'(FrameStart), 32'(m_active && m_cnt == 0));
      chk("WinEn", 32'(WinEn), 32'(we));
      chk("WinAddr", 32'(WinAddr), m_active ? 32'(wcnt) : 32'd0);
   endtask

   // one clock with the given run level, then advance model and compare
   task automatic tick(input bit r);
      run = r;
      @(posedge clk);
      if (!m_active) begin
         if (r) begin m_active = 1'b1; m_cnt = 0; end
      end else if (m_cnt == FR - 1) begin
         if (r) m_cnt = 0; else m_active = 1'b0;
      end else begin
         m_cnt++;
      end
      #1;
      check_all();
   endtask

   initial begin
      int n, fs_n, de_n, we_n, len;
      bit lvl;
      // reset state
      #23;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick(1'b0);

      // run held: one frame's worth of strobes
      fs_n = 0; de_n = 0; we_n = 0;
      for (int i = 0; i < FR; i++) begin
         tick(1'b1);
         fs_n += FrameStart; de_n += DataEnable; we_n += WinEn;
      end
      chk("fs_per_frame", 32'(fs_n), 32'd1);
      chk("de_per_frame", 32'(de_n), 32'(SX * SY));
      chk("win_per_frame", 32'(we_n), 32'(WX * WY));
      tick(1'b1);
      chk("fs_period", 32'(FrameStart), 32'd1);

      // drop run at (3,1): drain to the last pixel then go idle
      n = 0;
      while (!(PosX == 11'd3 && PosY == 11'd1) && n < 200) begin tick(1'b1); n++; end
      chk("reach_3_1", 32'(n < 200), 32'd1);
      n = 0;
      while (!(PosX == 11'(HT - 1) && PosY == 11'(VT - 1)) && n < 200) begin tick(1'b0); n++; end
      chk("drain_len", 32'(n), 32'(FR - 1 - (HT + 3)));
      tick(1'b0);
      chk("drain_idle_fs", 32'(FrameStart), 32'd0);
      repeat (5) tick(1'b0);

      // drop then re-raise run mid-frame: no gap, one FrameStart per frame
      fs_n = 0;
      tick(1'b1);
      for (int i = 1; i < FR; i++) begin
         tick(!(i >= 20 && i < 30));
         fs_n += FrameStart;
      end
      chk("redrain_no_fs", 32'(fs_n), 32'd0);
      tick(1'b1);
      chk("redrain_next_fs", 32'(FrameStart), 32'd1);

      // randomized run levels held for random lengths
      for (int s = 0; s < 40; s++) begin
         lvl = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 60);
         repeat (len) tick(lvl);
      end

      // asynchronous reset while DataEnable is high mid-line
      n = 0;
      tick(1'b1);
      while (!(DataEnable && PosX == 11'd2) && n < 200) begin tick(1'b1); n++; end
      chk("reach_de", 32'(DataEnable), 32'd1);
      #2;
      rst_n = 1'b0;
      m_active = 1'b0;
      #1;
      chk("rst_de", 32'(DataEnable), 32'd0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b1);
      chk("rst_fs", 32'(FrameStart), 32'd1);
      repeat (20) tick(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
